// File: rtl/flit_stream_checker_pkg.sv
// Shared types and helpers for the flit stream checker: flit classification,
// packet-type names and the per-VC length counter width.
package flit_stream_checker_pkg;

  typedef enum logic [1:0] {
    FT_HDR    = 2'd0,
    FT_BODY   = 2'd1,
    FT_TAIL   = 2'd2,
    FT_SINGLE = 2'd3
  } flit_type_e;

  localparam string PCK_MULTI_FLIT  = "MULTI_FLIT";
  localparam string PCK_SINGLE_FLIT = "SINGLE_FLIT";

  function automatic flit_type_e decode_flit(input logic hdr, input logic tail);
    case ({hdr, tail})
      2'b11:   return FT_SINGLE;
      2'b10:   return FT_HDR;
      2'b01:   return FT_TAIL;
      default: return FT_BODY;
    endcase
  endfunction

  // Counter must hold MAX_PCK_SIZE+1, the saturation value that marks an oversize packet.
  function automatic int cnt_width(input int max_pck);
    return $clog2(max_pck + 2);
  endfunction

endpackage

// File: rtl/flit_vc_tracker.sv
// Framing state of one virtual channel: open flag plus saturating flit count.
// Emits combinational order/size error pulses for the flit currently presented.
module flit_vc_tracker
  import flit_stream_checker_pkg::*;
#(
  parameter int MIN_PCK_SIZE = 2,
  parameter int MAX_PCK_SIZE = 64,
  parameter bit SINGLE_FLIT  = 1'b0,
  parameter int CW           = cnt_width(MAX_PCK_SIZE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flit_valid,
  input  flit_type_e flit_type,
  output logic       order_err,
  output logic       size_err
);

  localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_PCK_SIZE);
  localparam logic [CW-1:0] CNT_SAT    = CW'(MAX_PCK_SIZE + 1);
  localparam logic [CW-1:0] LEN_MIN_M1 = CW'(MIN_PCK_SIZE - 1);

  logic          open_reg;
  logic [CW-1:0] cnt_reg;

  always_comb begin
    order_err = 1'b0;
    size_err  = 1'b0;
    if (flit_valid) begin
      if (SINGLE_FLIT) begin
        order_err = (flit_type != FT_SINGLE);
        size_err  = (flit_type == FT_SINGLE) && (MIN_PCK_SIZE > 1);
      end else begin
        case (flit_type)
          FT_SINGLE: begin
            order_err = open_reg;
            size_err  = (MIN_PCK_SIZE > 1);
          end
          FT_HDR: order_err = open_reg;
          // Flag the packet the moment it grows past MAX, not only at its tail.
          FT_BODY: begin
            order_err = !open_reg;
            size_err  = open_reg && (cnt_reg == CNT_MAX);
          end
          default: begin
            order_err = !open_reg;
            size_err  = open_reg && ((cnt_reg < LEN_MIN_M1) || (cnt_reg >= CNT_MAX));
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (flit_valid && !SINGLE_FLIT) begin
      case (flit_type)
        FT_HDR: begin
          open_reg <= 1'b1;
          cnt_reg  <= CW'(1);
        end
        FT_BODY: begin
          if (open_reg && (cnt_reg != CNT_SAT)) cnt_reg <= cnt_reg + CW'(1);
        end
        default: begin
          open_reg <= 1'b0;
          cnt_reg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/flit_stream_checker.sv
// Passive per-port flit framing monitor with sticky error flags.
// Optional destination range check enabled by defining FLIT_CHECK_DEST_EN.
module flit_stream_checker
  import flit_stream_checker_pkg::*;
#(
  parameter int    V            = 4,
  parameter string PCK_TYPE     = PCK_MULTI_FLIT,
  parameter int    MIN_PCK_SIZE = 2,
  parameter int    MAX_PCK_SIZE = 64,
  parameter int    DAw          = 8,
  parameter int    NE           = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flit_in_wr,
  input  logic           hdr_flg_in,
  input  logic           tail_flg_in,
  input  logic [V-1:0]   vc_num_in,
  input  logic [DAw-1:0] dest_e_addr_in,
  output logic           err_order,
  output logic           err_size,
  output logic           err_dest,
  output logic [V-1:0]   err_vc
);

  localparam bit SINGLE_MODE = (PCK_TYPE == PCK_SINGLE_FLIT);

  flit_type_e   flit_type;
  logic         vc_onehot;
  logic [V-1:0] order_vec;
  logic [V-1:0] size_vec;
  logic         order_hit;
  logic         size_hit;
  logic         dest_hit;

  logic         err_order_reg;
  logic         err_size_reg;
  logic         err_dest_reg;
  logic [V-1:0] err_vc_reg;

  assign flit_type = decode_flit(hdr_flg_in, tail_flg_in);
  assign vc_onehot = $onehot(vc_num_in);

  generate
    for (genvar gi = 0; gi < V; gi++) begin : g_vc
      flit_vc_tracker #(
        .MIN_PCK_SIZE(MIN_PCK_SIZE),
        .MAX_PCK_SIZE(MAX_PCK_SIZE),
        .SINGLE_FLIT (SINGLE_MODE)
      ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .flit_valid(flit_in_wr && vc_onehot && vc_num_in[gi]),
        .flit_type (flit_type),
        .order_err (order_vec[gi]),
        .size_err  (size_vec[gi])
      );
    end
  endgenerate

  // A malformed VC field is a framing error; the flit reaches no tracker.
  assign order_hit = flit_in_wr && (!vc_onehot || (|order_vec));
  assign size_hit  = |size_vec;

`ifdef FLIT_CHECK_DEST_EN
  assign dest_hit = flit_in_wr && hdr_flg_in && (32'(dest_e_addr_in) >= NE);
`else
  logic unused_dest;
  assign unused_dest = ^dest_e_addr_in;
  assign dest_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      err_order_reg <= 1'b0;
      err_size_reg  <= 1'b0;
      err_dest_reg  <= 1'b0;
      err_vc_reg    <= '0;
    end else begin
      if (order_hit) err_order_reg <= 1'b1;
      if (size_hit)  err_size_reg  <= 1'b1;
      if (dest_hit)  err_dest_reg  <= 1'b1;
      if (order_hit || size_hit || dest_hit) err_vc_reg <= err_vc_reg | vc_num_in;
    end
  end

  assign err_order = err_order_reg;
  assign err_size  = err_size_reg;
  assign err_dest  = err_dest_reg;
  assign err_vc    = err_vc_reg;

endmodule

// File: tb/tb_flit_stream_checker.sv
// Bench for flit_stream_checker: directed scenarios plus randomized flits checked
// against a packet-level reference model; honours FLIT_CHECK_DEST_EN.
module tb_flit_stream_checker;

  localparam int V   = 4;
  localparam int MIN = 2;
  localparam int MAX = 4;
  localparam int DAw = 8;
  localparam int NE  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           flit_in_wr;
  logic           hdr_flg_in;
  logic           tail_flg_in;
  logic [V-1:0]   vc_num_in;
  logic [DAw-1:0] dest_e_addr_in;
  logic           err_order;
  logic           err_size;
  logic           err_dest;
  logic [V-1:0]   err_vc;

  always #5 clk = ~clk;

  flit_stream_checker #(
    .V(V), .PCK_TYPE("MULTI_FLIT"), .MIN_PCK_SIZE(MIN), .MAX_PCK_SIZE(MAX), .DAw(DAw), .NE(NE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flit_in_wr    (flit_in_wr),
    .hdr_flg_in    (hdr_flg_in),
    .tail_flg_in   (tail_flg_in),
    .vc_num_in     (vc_num_in),
    .dest_e_addr_in(dest_e_addr_in),
    .err_order     (err_order),
    .err_size      (err_size),
    .err_dest      (err_dest),
    .err_vc        (err_vc)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: whether a packet is in flight per VC and its true length.
  bit         m_open[V];
  int         m_len[V];
  logic       e_order, e_size, e_dest;
  logic [V-1:0] e_vc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < V; i++) begin
      m_open[i] = 1'b0;
      m_len[i]  = 0;
    end
    e_order = 1'b0; e_size = 1'b0; e_dest = 1'b0; e_vc = '0;
  endtask

  task automatic model_flit(input logic hdr, input logic tail, input logic [V-1:0] vc,
                            input logic [DAw-1:0] dest);
    bit o = 0, s = 0, d = 0;
    int i = 0;
    if ($countones(vc) != 1) begin
      o = 1;
    end else begin
      for (int k = 0; k < V; k++) if (vc[k]) i = k;
      if (hdr && tail) begin
        if (m_open[i]) o = 1;
        if (1 < MIN || 1 > MAX) s = 1;
        m_open[i] = 0; m_len[i] = 0;
      end else if (hdr) begin
        if (m_open[i]) o = 1;
        m_open[i] = 1; m_len[i] = 1;
      end else if (!m_open[i]) begin
        o = 1;
      end else begin
        m_len[i] = m_len[i] + 1;
        if (tail) begin
          if (m_len[i] < MIN || m_len[i] > MAX) s = 1;
          m_open[i] = 0; m_len[i] = 0;
        end else if (m_len[i] == MAX + 1) begin
          s = 1;
        end
      end
    end
`ifdef FLIT_CHECK_DEST_EN
    if (hdr && int'(dest) >= NE) d = 1;
`endif
    if (o) e_order = 1'b1;
    if (s) e_size  = 1'b1;
    if (d) e_dest  = 1'b1;
    if (o || s || d) e_vc = e_vc | vc;
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, "_order"}, 32'(err_order), 32'(e_order));
    check_val({tag, "_size"},  32'(err_size),  32'(e_size));
    check_val({tag, "_dest"},  32'(err_dest),  32'(e_dest));
    check_val({tag, "_vc"},    32'(err_vc),    32'(e_vc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flit_in_wr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    compare_all("rst");
  endtask

  task automatic send(input logic wr, input logic hdr, input logic tail,
                      input logic [V-1:0] vc, input logic [DAw-1:0] dest, input string tag);
    @(negedge clk);
    flit_in_wr = wr; hdr_flg_in = hdr; tail_flg_in = tail;
    vc_num_in = vc; dest_e_addr_in = dest;
    if (wr) model_flit(hdr, tail, vc, dest);
    @(posedge clk);
    #1;
    flit_in_wr = 1'b0;
    if (wr) $display("txn %s hdr=%0b tail=%0b vc=%b dest=%0d -> ord=%0b sz=%0b dst=%0b vc=%b",
                     tag, hdr, tail, vc, dest, err_order, err_size, err_dest, err_vc);
    compare_all(tag);
  endtask

  initial begin
    reset = 1'b1; flit_in_wr = 1'b0; hdr_flg_in = 1'b0; tail_flg_in = 1'b0;
    vc_num_in = '0; dest_e_addr_in = '0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();
    check_val("rst_const_vc", 32'(err_vc), 32'd0);

    // Legal three-flit packet on VC1.
    send(1, 1, 0, 4'b0010, 8'd3, "t1_hdr");
    send(1, 0, 0, 4'b0010, 8'd0, "t1_body");
    send(1, 0, 1, 4'b0010, 8'd0, "t1_tail");
    check_val("t1_clean", 32'({err_order, err_size, err_vc}), 32'd0);

    // Orphan body on VC0, flag must persist.
    do_reset();
    send(1, 0, 0, 4'b0001, 8'd0, "t2_body");
    check_val("t2_order", 32'(err_order), 32'd1);
    check_val("t2_vc", 32'(err_vc), 32'b0001);
    for (int i = 0; i < 10; i++) send(0, 0, 0, 4'b0000, 8'd0, "t2_hold");
    check_val("t2_order_held", 32'(err_order), 32'd1);

    // One-flit packet shorter than MIN.
    do_reset();
    send(1, 1, 1, 4'b0100, 8'd1, "t3_single");
    check_val("t3_size", 32'(err_size), 32'd1);
    check_val("t3_vc", 32'(err_vc), 32'b0100);
    check_val("t3_order", 32'(err_order), 32'd0);

    // Oversize packet flagged on the flit that exceeds MAX.
    do_reset();
    send(1, 1, 0, 4'b1000, 8'd2, "t4_hdr");
    for (int i = 0; i < 3; i++) send(1, 0, 0, 4'b1000, 8'd0, "t4_body");
    check_val("t4_size_early", 32'(err_size), 32'd0);
    send(1, 0, 0, 4'b1000, 8'd0, "t4_body5");
    check_val("t4_size", 32'(err_size), 32'd1);
    send(1, 0, 1, 4'b1000, 8'd0, "t4_tail");
    check_val("t4_order", 32'(err_order), 32'd0);

    // Interleaved VCs, then reset mid-stream.
    do_reset();
    send(1, 1, 0, 4'b0001, 8'd4, "t5_hdr0");
    send(1, 1, 0, 4'b0010, 8'd5, "t5_hdr1");
    send(1, 0, 1, 4'b0001, 8'd0, "t5_tail0");
    send(1, 0, 0, 4'b0010, 8'd0, "t5_body1");
    send(1, 0, 1, 4'b0010, 8'd0, "t5_tail1");
    check_val("t5_clean", 32'({err_order, err_size, err_vc}), 32'd0);
    send(1, 1, 0, 4'b0001, 8'd4, "t5_hdr0b");
    do_reset();
    send(1, 0, 1, 4'b0001, 8'd0, "t5_tail_after_rst");
    check_val("t5_order", 32'(err_order), 32'd1);

    // Destination range.
    do_reset();
    send(1, 1, 0, 4'b0001, 8'd15, "t6_dest15");
    check_val("t6_dest15", 32'(err_dest), 32'd0);
    send(1, 1, 0, 4'b0010, 8'd16, "t6_dest16");
`ifdef FLIT_CHECK_DEST_EN
    check_val("t6_dest16", 32'(err_dest), 32'd1);
`else
    check_val("t6_dest16", 32'(err_dest), 32'd0);
`endif

    // Bad VC encodings.
    do_reset();
    send(1, 1, 0, 4'b0000, 8'd0, "t7_vc_zero");
    check_val("t7_order", 32'(err_order), 32'd1);
    do_reset();
    send(1, 1, 0, 4'b0110, 8'd0, "t7_vc_multi");
    check_val("t7_vc", 32'(err_vc), 32'b0110);

    // Randomized traffic, reset periodically so flags stay informative.
    for (int r = 0; r < 30; r++) begin
      do_reset();
      for (int c = 0; c < 20; c++) begin
        int t;
        logic h, tl, wr;
        logic [V-1:0] vc;
        t  = int'($urandom_range(0, 9));
        h  = (t <= 2) || (t == 9);
        tl = (t == 7) || (t == 8) || (t == 9);
        wr = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 14) == 0) vc = V'($urandom);
        else vc = V'(1) << $urandom_range(0, V - 1);
        send(wr, h, tl, vc, DAw'($urandom_range(0, 20)), "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
